// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: requester drives start/a/b,
// the subtractor returns status and the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one full-subtractor cell and a borrow flop walk the operands
// LSB first; results are published together on the cycle the FSM enters DONE.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] sd;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb, b_msb;

    logic             busy_q, done_q, bo_q, ovf_q;
    logic [WIDTH-1:0] diff_q;

    logic             ai, bi, d_bit, br_nxt, last;
    logic [WIDTH-1:0] sd_nxt;

    // Full-subtractor cell on the current LSBs of the shift registers.
    always_comb begin
        ai     = sa[0];
        bi     = sb[0];
        d_bit  = ai ^ bi ^ br;
        br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
        sd_nxt = {d_bit, sd};
        last   = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            diff_q <= '0;
            bo_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_nxt[WIDTH-1:1];
                    br  <= br_nxt;
                    cnt <= cnt + 1'b1;
                    // The last bit's cell output is the MSB, so the whole result
                    // is complete in sd_nxt and loads in one shot.
                    if (last) begin
                        diff_q <= sd_nxt;
                        bo_q   <= br_nxt;
                        ovf_q  <= (a_msb != b_msb) && (d_bit != a_msb);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bo_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): hand-computed results, latency,
// start-ignore, async abort and back-to-back throughput.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errs    = 0;

    logic [W-1:0] pd = '0;
    logic         pb = 1'b0, po = 1'b0;

    serial_subtractor_if #(.WIDTH(W)) ifc ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation; optionally poke start with junk operands in RUN and DONE.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic eb, input logic eo, input bit glitch);
        int bcnt;
        int early;
        bcnt  = 0;
        early = 0;
        ifc.start = 1'b1; ifc.a = a; ifc.b = b;
        @(posedge clk); #1;
        ifc.start = 1'b0; ifc.a = ~a; ifc.b = 8'h5A;
        for (int i = 0; i < W; i++) begin
            if (ifc.busy) bcnt++;
            if (ifc.done) early++;
            if (i == 4) check({tag, " held"}, 32'(ifc.diff), 32'(pd));
            ifc.start = glitch && (i == 2);
            if (glitch && i == 2) begin ifc.a = 8'hFF; ifc.b = 8'h00; end
            @(posedge clk); #1;
        end
        check({tag, " busy_cycles"}, 32'(bcnt), 32'(W));
        check({tag, " early_done"}, 32'(early), 32'd0);
        check({tag, " done"}, 32'({ifc.done, ifc.busy}), 32'b10);
        check({tag, " diff"}, 32'(ifc.diff), 32'(ed));
        check({tag, " borrow_ovf"}, 32'({ifc.borrow_out, ifc.ovf}), 32'({eb, eo}));
        if (glitch) begin ifc.start = 1'b1; ifc.a = 8'h11; ifc.b = 8'h22; end
        @(posedge clk); #1;
        ifc.start = 1'b0;
        check({tag, " after"}, 32'({ifc.done, ifc.busy, ifc.diff, ifc.borrow_out, ifc.ovf}),
              32'({1'b0, 1'b0, ed, eb, eo}));
        pd = ed; pb = eb; po = eo;
    endtask

    logic [W-1:0] ba [3] = '{8'h3C, 8'h90, 8'h7F};
    logic [W-1:0] bb [3] = '{8'h5A, 8'h20, 8'h01};
    logic [W-1:0] bd [3] = '{8'hE2, 8'h70, 8'h7E};
    logic         bbo[3] = '{1'b1, 1'b0, 1'b0};
    logic         bov[3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int dones;
        ifc.start = 1'b0; ifc.a = '0; ifc.b = '0;
        #1;
        check("reset outputs", 32'({ifc.busy, ifc.done, ifc.diff, ifc.borrow_out, ifc.ovf}), 32'd0);
        #11 rst = 1'b0;
        @(posedge clk); #1;
        check("idle no start", 32'({ifc.busy, ifc.done}), 32'd0);

        do_op("2D-0F", 8'h2D, 8'h0F, 8'h1E, 1'b0, 1'b0, 1'b0);
        do_op("05-0A", 8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0, 1'b0);
        do_op("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op("ignore", 8'h64, 8'h19, 8'h4B, 1'b0, 1'b0, 1'b1);
        do_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        do_op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);

        // Abort mid-run with an asynchronous reset between edges.
        ifc.start = 1'b1; ifc.a = 8'h12; ifc.b = 8'h34;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort async", 32'({ifc.busy, ifc.done, ifc.diff, ifc.borrow_out, ifc.ovf}), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ifc.done || ifc.busy) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        pd = '0; pb = 1'b0; po = 1'b0;
        do_op("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);

        // start held high: one result every W+2 cycles.
        ifc.start = 1'b1; ifc.a = ba[0]; ifc.b = bb[0];
        @(posedge clk); #1;
        for (int n = 0; n < 3; n++) begin
            if (n < 2) begin ifc.a = ba[n+1]; ifc.b = bb[n+1]; end
            check("b2b busy", 32'(ifc.busy), 32'd1);
            repeat (W) @(posedge clk);
            #1;
            check("b2b done", 32'({ifc.done, ifc.diff, ifc.borrow_out, ifc.ovf}),
                  32'({1'b1, bd[n], bbo[n], bov[n]}));
            @(posedge clk); #1;
            check("b2b idle", 32'({ifc.done, ifc.busy}), 32'd0);
            if (n == 2) ifc.start = 1'b0;
            @(posedge clk); #1;
        end
        check("b2b stop", 32'(ifc.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled on rising clk edge.
REQ-005 a  input  WIDTH  minuend, unsigned or two's complement.
REQ-006 b  input  WIDTH  subtrahend, unsigned or two's complement.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  single-cycle pulse: results valid and newly updated.
REQ-009 diff  output  WIDTH  result a - b modulo 2^WIDTH.
REQ-010 borrow_out  output  1  unsigned borrow: 1 when a < b (unsigned).
REQ-011 ovf  output  1  signed overflow of a - b in two's complement.

Function
REQ-012 Block SHALL compute a - b bit-serially, LSB first, one bit per clk cycle, via a single full-subtractor cell plus a 1-bit borrow register.
REQ-013 Per-bit rule SHALL be: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); br = 0 for bit 0.
REQ-014 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 IDLE: on edge with start=1, SHALL capture a and b into internal shift registers, clear borrow register and bit counter, enter RUN, set busy=1.
REQ-016 IDLE: start=0 SHALL hold state; a/b changes SHALL have no effect.
REQ-017 RUN: each edge SHALL process one bit and increment the counter; after the WIDTH-th RUN edge SHALL enter DONE.
REQ-018 Start edge at cycle k SHALL give done=1 and busy=0 after edge k+WIDTH (latency WIDTH cycles from start edge to done).
REQ-019 On the edge entering DONE, diff, borrow_out (final borrow) and ovf SHALL be loaded simultaneously.
REQ-020 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) using captured operands.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE unconditionally; done SHALL be 0 outside DONE.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing; captured operands SHALL not change.
REQ-023 a and b inputs SHALL be don't-care after the start edge.
REQ-024 diff, borrow_out, ovf SHALL hold their last values in IDLE and during the following RUN until the next DONE load; they SHALL not show partial results.
REQ-025 busy SHALL be 1 exactly in RUN.
REQ-026 Back-to-back: start held high continuously SHALL yield one operation per WIDTH+2 cycles (IDLE, WIDTH x RUN, DONE).
REQ-027 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-028 rst=1 SHALL immediately (without clk) force state IDLE, busy=0, done=0, diff=0, borrow_out=0, ovf=0, borrow register and counter 0.
REQ-029 rst asserted mid-RUN SHALL abort the operation; no done pulse and no result update for the aborted operation.
REQ-030 After rst deasserts, first start edge SHALL behave as REQ-015.

Verification (WIDTH=8)
REQ-031 a=0x2D, b=0x0F, start 1 cycle -> after 8 edges done=1, diff=0x1E, borrow_out=0, ovf=0; next cycle done=0, outputs held.
REQ-032 a=0x05, b=0x0A -> diff=0xFB, borrow_out=1, ovf=0; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-033 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
REQ-034 start pulsed again at RUN cycle 3 and in DONE with changed a/b -> ignored; result matches first operands; busy high exactly 8 cycles.
REQ-035 rst asserted asynchronously at RUN cycle 4 (mid-clock) -> outputs 0 immediately, no done; then a=0xFF, b=0xFF -> diff=0x00, borrow_out=0, ovf=0.
REQ-036 start held high for 3 operations with random a/b -> done every 10 cycles, each result equals reference a-b, borrow and ovf.
